// File: rtl/wb_stage.sv
// Writeback stage: M/W pipeline register, register-file write port, and cycle/instret counters.
// Optional macro WB_HALT_EN adds a sticky halt flag that is set when an ECALL retires.
module wb_stage #(
   parameter int unsigned      XLEN     = 32,
   parameter int unsigned      CNT_W    = 64,
   parameter logic [31:0]      NOP_INST = 32'h0000_0013,
   parameter logic [XLEN-1:0]  RESET_PC = XLEN'(32'h0100_0000)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             flush,
   input  logic             valid_m,
   input  logic [31:0]      inst_m,
   input  logic [XLEN-1:0]  pc_m,
   input  logic [XLEN-1:0]  wb_m,
   output logic             valid_w,
   output logic [31:0]      inst_w,
   output logic [XLEN-1:0]  pc_w,
   output logic             reg_we,
   output logic [4:0]       reg_rd,
   output logic [XLEN-1:0]  reg_wdata,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instret_cnt,
   output logic             halt
);

   localparam logic [6:0] OpLui    = 7'b0110111;
   localparam logic [6:0] OpAuipc  = 7'b0010111;
   localparam logic [6:0] OpJal    = 7'b1101111;
   localparam logic [6:0] OpJalr   = 7'b1100111;
   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpOpImm  = 7'b0010011;
   localparam logic [6:0] OpOp     = 7'b0110011;

   logic             valid_q, valid_d;
   logic [31:0]      inst_q, inst_d;
   logic [XLEN-1:0]  pc_q, pc_d;
   logic [XLEN-1:0]  wdata_q, wdata_d;
   logic [CNT_W-1:0] cycle_q, instret_q;
   logic             halt_int;
   logic             retire;
   logic             rd_writer;

   // Flush beats stall; stall holds everything.
   always_comb begin
      valid_d = valid_q;
      inst_d  = inst_q;
      pc_d    = pc_q;
      wdata_d = wdata_q;
      if (flush) begin
         valid_d = 1'b0;
         inst_d  = NOP_INST;
         pc_d    = RESET_PC;
         wdata_d = '0;
      end else if (!stall) begin
         valid_d = valid_m;
         inst_d  = inst_m;
         pc_d    = pc_m;
         wdata_d = wb_m;
      end
   end

   // The occupant leaving W is counted even when a flush replaces it.
   assign retire = valid_q & ~stall & ~halt_int;

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q   <= 1'b0;
         inst_q    <= NOP_INST;
         pc_q      <= RESET_PC;
         wdata_q   <= '0;
         cycle_q   <= '0;
         instret_q <= '0;
      end else begin
         valid_q   <= valid_d;
         inst_q    <= inst_d;
         pc_q      <= pc_d;
         wdata_q   <= wdata_d;
         cycle_q   <= cycle_q + CNT_W'(1);
         if (retire) instret_q <= instret_q + CNT_W'(1);
      end
   end

`ifdef WB_HALT_EN
   localparam logic [31:0] InstEcall = 32'h0000_0073;
   logic halt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         halt_q <= 1'b0;
      end else if (valid_q && !stall && inst_q == InstEcall) begin
         halt_q <= 1'b1;
      end
   end

   assign halt_int = halt_q;
`else
   assign halt_int = 1'b0;
`endif

   always_comb begin
      rd_writer = 1'b0;
      case (inst_q[6:0])
         OpLui, OpAuipc, OpJal, OpJalr, OpLoad, OpOpImm, OpOp: rd_writer = 1'b1;
         default:                                              rd_writer = 1'b0;
      endcase
   end

   assign valid_w     = valid_q;
   assign inst_w      = inst_q;
   assign pc_w        = pc_q;
   assign reg_wdata   = wdata_q;
   assign reg_rd      = inst_q[11:7];
   assign reg_we      = valid_q & ~halt_int & (inst_q[11:7] != 5'd0) & rd_writer;
   assign cycle_cnt   = cycle_q;
   assign instret_cnt = instret_q;
   assign halt        = halt_int;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: a transaction-level model of the W slot and counters is
// checked every cycle, plus literal expectations taken from hand-decoded instructions.
module tb_wb_stage;

   logic        clk = 1'b0;
   logic        rst, stall, flush, valid_m;
   logic [31:0] inst_m, pc_m, wb_m;
   logic        valid_w, reg_we, halt;
   logic [31:0] inst_w, pc_w, reg_wdata;
   logic [4:0]  reg_rd;
   logic [63:0] cycle_cnt, instret_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   wb_stage dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_m(valid_m),
      .inst_m(inst_m), .pc_m(pc_m), .wb_m(wb_m), .valid_w(valid_w), .inst_w(inst_w),
      .pc_w(pc_w), .reg_we(reg_we), .reg_rd(reg_rd), .reg_wdata(reg_wdata),
      .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt), .halt(halt)
   );

   always #5 clk = ~clk;

`ifdef WB_HALT_EN
   localparam bit HaltEn = 1'b1;
`else
   localparam bit HaltEn = 1'b0;
`endif

   // Model state: what the W slot holds and what the counters must read.
   typedef struct {
      bit        v;
      bit [31:0] inst;
      bit [31:0] pc;
      bit [31:0] wd;
   } slot_t;

   slot_t       m_w;
   bit   [63:0] m_cyc, m_ret;
   bit          m_halt;
   bit          m_ok = 1'b0;

   function automatic bit writes_rd(bit [31:0] inst);
      bit [6:0] ops [7] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h03, 7'h13, 7'h33};
      foreach (ops[i]) if (inst[6:0] == ops[i]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      if (rst) begin
         m_w    = '{v: 1'b0, inst: 32'h13, pc: 32'h0100_0000, wd: 32'h0};
         m_cyc  = 0;
         m_ret  = 0;
         m_halt = 1'b0;
         m_ok   = 1'b1;
      end else if (m_ok) begin
         m_cyc++;
         if (m_w.v && !stall && !m_halt) m_ret++;
         if (HaltEn && m_w.v && !stall && m_w.inst == 32'h73) m_halt = 1'b1;
         if (flush) m_w = '{v: 1'b0, inst: 32'h13, pc: 32'h0100_0000, wd: 32'h0};
         else if (!stall) m_w = '{v: valid_m, inst: inst_m, pc: pc_m, wd: wb_m};
      end
   end

   always @(negedge clk) begin
      if (m_ok) begin
         check("valid_w", 64'(valid_w), 64'(m_w.v));
         check("inst_w", 64'(inst_w), 64'(m_w.inst));
         check("pc_w", 64'(pc_w), 64'(m_w.pc));
         check("reg_wdata", 64'(reg_wdata), 64'(m_w.wd));
         check("reg_rd", 64'(reg_rd), 64'(m_w.inst[11:7]));
         check("reg_we", 64'(reg_we),
               64'(m_w.v && !m_halt && m_w.inst[11:7] != 0 && writes_rd(m_w.inst)));
         check("cycle_cnt", cycle_cnt, m_cyc);
         check("instret_cnt", instret_cnt, m_ret);
         check("halt", 64'(halt), 64'(m_halt));
      end
   end

   // Apply inputs just after a falling edge and wait for the next falling edge.
   task automatic drive(input bit v, input bit [31:0] inst, input bit [31:0] pc,
                        input bit [31:0] wb, input bit st, input bit fl);
      valid_m = v;
      inst_m  = inst;
      pc_m    = pc;
      wb_m    = wb;
      stall   = st;
      flush   = fl;
      @(negedge clk);
   endtask

   task automatic bubble();
      drive(1'b0, 32'h13, 32'h0, 32'h0, 1'b0, 1'b0);
   endtask

   bit [31:0] table_inst [7] = '{32'h1234_52b7, 32'h0000_0317, 32'h0000_80e7, 32'h0020_81b3,
                                 32'h0000_0063, 32'h0000_0fff, 32'h0000_0037};

   initial begin
      rst = 1'b1;
      {stall, flush, valid_m} = 3'b000;
      inst_m = 32'h13;
      pc_m = 0;
      wb_m = 0;
      @(negedge clk);
      @(negedge clk);
      check("rst valid_w", 64'(valid_w), 64'd0);
      check("rst inst_w", 64'(inst_w), 64'h13);
      check("rst pc_w", 64'(pc_w), 64'h0100_0000);
      check("rst reg_we", 64'(reg_we), 64'd0);
      check("rst cycle", cycle_cnt, 64'd0);
      check("rst instret", instret_cnt, 64'd0);
      rst = 1'b0;

      // addi x5,x0,7
      drive(1'b1, 32'h0070_0293, 32'h100, 32'd7, 1'b0, 1'b0);
      check("addi reg_we", 64'(reg_we), 64'd1);
      check("addi reg_rd", 64'(reg_rd), 64'd5);
      check("addi reg_wdata", 64'(reg_wdata), 64'd7);
      check("addi instret before", instret_cnt, 64'd0);
      bubble();
      check("addi instret after", instret_cnt, 64'd1);

      // addi x0,x0,9 and sw x5,0(x0): retire without writing
      drive(1'b1, 32'h0090_0013, 32'h104, 32'd9, 1'b0, 1'b0);
      check("addi x0 reg_we", 64'(reg_we), 64'd0);
      drive(1'b1, 32'h0050_2023, 32'h108, 32'd0, 1'b0, 1'b0);
      check("sw reg_we", 64'(reg_we), 64'd0);
      bubble();
      check("x0/sw instret", instret_cnt, 64'd3);

      // lw x6,0(x0) held by a 3-cycle stall
      drive(1'b1, 32'h0000_2303, 32'h10c, 32'hdead_beef, 1'b0, 1'b0);
      check("lw cycle", cycle_cnt, 64'd6);
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'h0010_0393, 32'h200 + 32'(i), 32'h55, 1'b1, 1'b0);
         check("stall reg_we", 64'(reg_we), 64'd1);
         check("stall inst_w", 64'(inst_w), 64'h0000_2303);
         check("stall wdata", 64'(reg_wdata), 64'hdead_beef);
         check("stall instret", instret_cnt, 64'd3);
      end
      bubble();
      check("lw instret", instret_cnt, 64'd4);
      check("lw cycle +4", cycle_cnt, 64'd10);

      // jal x1,8 then flush together with stall: leaving jal is not counted
      drive(1'b1, 32'h0080_00ef, 32'h110, 32'h114, 1'b0, 1'b0);
      check("jal reg_we", 64'(reg_we), 64'd1);
      drive(1'b1, 32'h0010_0393, 32'h114, 32'h1, 1'b1, 1'b1);
      check("flush valid_w", 64'(valid_w), 64'd0);
      check("flush inst_w", 64'(inst_w), 64'h13);
      check("flush pc_w", 64'(pc_w), 64'h0100_0000);
      check("flush+stall instret", instret_cnt, 64'd4);

      // Flush alone still counts the leaving instruction
      drive(1'b1, 32'h0070_0293, 32'h118, 32'd3, 1'b0, 1'b0);
      drive(1'b1, 32'h0010_0393, 32'h11c, 32'd1, 1'b0, 1'b1);
      check("flush instret", instret_cnt, 64'd5);
      check("flush wdata", 64'(reg_wdata), 64'd0);

      // Opcode classes, x0 destinations, undefined opcode
      foreach (table_inst[i]) drive(1'b1, table_inst[i], 32'h300 + 32'(4 * i), $urandom, 1'b0, 1'b0);
      bubble();

      // ECALL then addi x7,x0,1
      drive(1'b1, 32'h0000_0073, 32'h400, 32'h0, 1'b0, 1'b0);
      check("ecall reg_we", 64'(reg_we), 64'd0);
      drive(1'b1, 32'h0010_0393, 32'h404, 32'd1, 1'b0, 1'b0);
      check("post-ecall halt", 64'(halt), 64'(HaltEn));
      check("post-ecall reg_we", 64'(reg_we), 64'(!HaltEn));
      bubble();
      bubble();

      // Reset in the middle of a stall+flush
      drive(1'b1, 32'h0070_0293, 32'h500, 32'd7, 1'b0, 1'b0);
      rst = 1'b1;
      drive(1'b1, 32'h0010_0393, 32'h504, 32'd1, 1'b1, 1'b1);
      rst = 1'b0;
      check("mid rst valid_w", 64'(valid_w), 64'd0);
      check("mid rst halt", 64'(halt), 64'd0);
      check("mid rst instret", instret_cnt, 64'd0);
      check("mid rst pc_w", 64'(pc_w), 64'h0100_0000);
      bubble();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
